inst_fetch_mem: RTL
===================

INST_FETCH_MEM -- requirements
Module: inst_fetch_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 64, number of instruction words (power of two, >=2).
REQ-003 The block SHALL have parameter ADDR_W, default 64, byte-address width.
REQ-004 The block SHALL have parameter NOP_INSN, default 32'h00000013, word returned on error.
REQ-005 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port req_valid, input, 1, fetch request present.
REQ-008 The block SHALL have port req_addr, input, ADDR_W, byte address of the instruction.
REQ-009 The block SHALL have port req_ready, output, 1, fetch request accepted this cycle when high with req_valid.
REQ-010 The block SHALL have port resp_valid, output, 1, response present.
REQ-011 The block SHALL have port resp_ready, input, 1, consumer takes the response.
REQ-012 The block SHALL have port resp_data, output, DATA_W, fetched instruction.
REQ-013 The block SHALL have port resp_err, output, 1, misaligned or out-of-range fetch.
REQ-014 The block SHALL have port ld_en, input, 1, program-load write strobe.
REQ-015 The block SHALL have port ld_idx, input, clog2(DEPTH), word index to load.
REQ-016 The block SHALL have port ld_data, input, DATA_W, word to load.
REQ-017 The block SHALL have port fetch_cnt, output, 16, count of accepted fetches.

Function
REQ-018 Storage SHALL be DEPTH words; word index = req_addr[clog2(DEPTH)+1:2].
REQ-019 FSM SHALL have states IDLE and RESP.
REQ-020 req_ready SHALL be 1 in IDLE, and in RESP only when resp_ready=1; purely combinational from state and resp_ready.
REQ-021 Accept (req_valid & req_ready) SHALL move to RESP, with resp_valid=1 and resp_data/resp_err valid the next cycle (latency 1).
REQ-022 In RESP with resp_ready=0, resp_valid, resp_data and resp_err SHALL hold unchanged.
REQ-023 In RESP with resp_ready=1 and no new accept, next state SHALL be IDLE with resp_valid=0.
REQ-024 In RESP with resp_ready=1 and a new accept the same cycle, the block SHALL stay in RESP with the new response next cycle (back-to-back, one fetch per cycle).
REQ-025 req_addr[1:0]!=0 SHALL give resp_err=1, resp_data=NOP_INSN.
REQ-026 req_addr >= DEPTH*4 (all ADDR_W bits compared) SHALL give resp_err=1, resp_data=NOP_INSN.
REQ-027 Error fetches SHALL otherwise follow the same handshake and latency as good fetches.
REQ-028 ld_en=1 SHALL write ld_data to word ld_idx at the clock edge, in any FSM state.
REQ-029 A load and an accepted fetch to the same index in the same cycle SHALL return the pre-load (old) word.
REQ-030 A load SHALL NOT alter a response already held in RESP.
REQ-031 fetch_cnt SHALL increment by 1 per accept, including error fetches, saturating at 16'hFFFF.

Reset
REQ-032 rst=1 SHALL asynchronously force state IDLE, resp_valid=0, resp_data=0, resp_err=0, fetch_cnt=0.
REQ-033 rst SHALL NOT clear storage contents.
REQ-034 A response pending when rst asserts SHALL be discarded and never presented.
REQ-035 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-036 Load idx 2=32'h00A98933, fetch addr 8, resp_ready=1 -> next cycle resp_valid=1, resp_data=32'h00A98933, resp_err=0, fetch_cnt=1.
REQ-037 Fetch addr 6 -> resp_err=1, resp_data=32'h00000013; fetch addr 256 (DEPTH=64) -> resp_err=1, resp_data=32'h00000013.
REQ-038 Fetch addr 0 with resp_ready=0 for 3 cycles -> resp_data stable, req_ready=0 throughout; resp_ready=1 -> IDLE next cycle.
REQ-039 Fetch addrs 0,4,8,12 on consecutive cycles with resp_ready=1 -> four responses on consecutive cycles, in order, fetch_cnt=4.
REQ-040 Same-cycle load idx 1=32'hDEADBEEF and fetch addr 4 (old 32'h11111111) -> resp_data=32'h11111111; refetch -> 32'hDEADBEEF.
REQ-041 rst asserted while resp_valid=1 -> resp_valid=0 immediately, fetch_cnt=0, storage preserved on later fetch.

Source files
------------

// File: rtl/inst_fetch_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | inst_fetch_mem: word-addressed instruction store with one-cycle fetch  |
// | response, valid/ready handshake and program-load write port.           |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module inst_fetch_mem #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 64,
    parameter int                ADDR_W   = 64,
    parameter logic [DATA_W-1:0] NOP_INSN = DATA_W'(32'h00000013)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_W-1:0]        resp_data,
    output logic                     resp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_idx,
    input  logic [DATA_W-1:0]        ld_data,
    output logic [15:0]              fetch_cnt
);

    localparam int         c_IDX_W = $clog2(DEPTH);
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_RESP  = 1'b1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [DATA_W-1:0]  r_data;
    logic               r_err;
    logic [15:0]        r_cnt;
    logic               w_accept;
    logic               w_misalign;
    logic               w_oor;
    logic               w_fault;
    logic [c_IDX_W-1:0] w_idx;

    assign w_misalign = |req_addr[1:0];
    // Any set bit above the word-index field means the address is past the store.
    assign w_oor      = |(req_addr >> (c_IDX_W + 2));
    assign w_fault    = w_misalign | w_oor;
    assign w_idx      = req_addr[c_IDX_W+1:2];

    assign req_ready  = (r_state == c_IDLE) | resp_ready;
    assign w_accept   = req_valid & req_ready;
    assign resp_valid = (r_state == c_RESP);
    assign resp_data  = r_data;
    assign resp_err   = r_err;
    assign fetch_cnt  = r_cnt;

    // Storage is intentionally outside the reset domain so programs survive rst.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_mem[ld_idx] <= ld_data;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_next = c_RESP;
            c_RESP:  if (resp_ready && !w_accept) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_data  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                // Non-blocking read sees the pre-load word on a same-cycle load.
                r_err  <= w_fault;
                r_data <= w_fault ? NOP_INSN : r_mem[w_idx];
                if (r_cnt != 16'hFFFF) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire
